// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state, word type
// and the memory arbiter state encoding.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      FREE   = 2'd0,
      BUSY   = 2'd1,
      ACCESS = 2'd2,
      ERROR  = 2'd3
   } ramstate_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISERVE = 2'd1,
      DSERVE = 2'd2,
      DHOLD  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Icache/dcache arbiter in front of a single-ported RAM,
// with dcache block pairing and bounded icache starvation.
module mem_arbiter
   import cpu_types_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        iREN,
   input  logic [31:0] iaddr,
   output logic        iwait,
   output logic [31:0] iload,
   input  logic        dREN,
   input  logic        dWEN,
   input  logic [31:0] daddr,
   input  logic [31:0] dstore,
   output logic        dwait,
   output logic [31:0] dload,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   input  logic [31:0] ramload,
   input  ramstate_t   ramstate
);

   localparam logic [3:0] SMAX = 4'(STARVE_MAX);

   arb_state_t state, nxt;
   arb_state_t resolved;
   logic [3:0] scnt, scnt_n;
   logic       dreq;
   logic       dwin;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state <= IDLE;
         scnt  <= '0;
      end else begin
         state <= nxt;
         scnt  <= scnt_n;
      end
   end

   always_comb begin
      nxt      = state;
      scnt_n   = scnt;
      iwait    = 1'b1;
      iload    = '0;
      dwait    = 1'b1;
      dload    = '0;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      dreq     = dREN | dWEN;
      // dcache wins ties until the icache has waited out STARVE_MAX grants
      dwin     = dreq && (!iREN || (scnt < SMAX));
      resolved = dwin ? DSERVE : (iREN ? ISERVE : IDLE);

      unique case (state)
         IDLE: begin
            nxt = resolved;
         end
         DHOLD: begin
            nxt = dreq ? DSERVE : resolved;
         end
         DSERVE: begin
            ramaddr  = daddr;
            ramstore = dstore;
            if (!dreq) begin
               nxt = IDLE;
            end else begin
               ramWEN = dWEN;
               ramREN = dREN & ~dWEN;
               if (ramstate == ACCESS) begin
                  dwait = 1'b0;
                  dload = ramload;
                  if (iREN)
                     scnt_n = (scnt == 4'hF) ? scnt
                                             : scnt + 4'd1;
                  else
                     scnt_n = '0;
                  nxt = daddr[2] ? IDLE : DHOLD;
               end
            end
         end
         ISERVE: begin
            if (!iREN) begin
               nxt = IDLE;
            end else begin
               ramREN  = 1'b1;
               ramaddr = iaddr;
               if (ramstate == ACCESS) begin
                  iwait  = 1'b0;
                  iload  = ramload;
                  scnt_n = '0;
                  nxt    = IDLE;
               end
            end
         end
         default: nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter plus
// reset, error-hold, starvation and async-reset sequences.
module tb_mem_arbiter;
   import cpu_types_pkg::*;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        iREN = 1'b0;
   logic [31:0] iaddr = '0;
   logic        iwait;
   logic [31:0] iload;
   logic        dREN = 1'b0;
   logic        dWEN = 1'b0;
   logic [31:0] daddr = '0;
   logic [31:0] dstore = '0;
   logic        dwait;
   logic [31:0] dload;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload = '0;
   ramstate_t   ramstate = FREE;

   int errors = 0;
   int checks = 0;

   mem_arbiter #(.STARVE_MAX(4)) dut (
      .CLK(CLK), .RST(RST),
      .iREN(iREN), .iaddr(iaddr),
      .iwait(iwait), .iload(iload),
      .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore),
      .dwait(dwait), .dload(dload),
      .ramREN(ramREN), .ramWEN(ramWEN),
      .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        iren;
      logic [31:0] ia;
      logic        dren;
      logic        dwen;
      logic [31:0] da;
      logic [31:0] ds;
      logic [31:0] rl;
      ramstate_t   rs;
      logic        e_iw;
      logic [31:0] e_il;
      logic        e_dw;
      logic [31:0] e_dl;
      logic        e_rr;
      logic        e_rw;
      logic [31:0] e_ra;
      logic [31:0] e_rs;
   } vec_t;

   vec_t vq[$];

   task automatic add(
      input logic ir, input logic [31:0] ia,
      input logic dr, input logic dw,
      input logic [31:0] da, input logic [31:0] ds,
      input logic [31:0] rl, input ramstate_t rs,
      input logic iw, input logic [31:0] il,
      input logic dwt, input logic [31:0] dl,
      input logic rr, input logic rw,
      input logic [31:0] ra, input logic [31:0] rst_);
      vec_t v;
      v.iren = ir; v.ia = ia; v.dren = dr; v.dwen = dw;
      v.da = da; v.ds = ds; v.rl = rl; v.rs = rs;
      v.e_iw = iw; v.e_il = il; v.e_dw = dwt; v.e_dl = dl;
      v.e_rr = rr; v.e_rw = rw; v.e_ra = ra; v.e_rs = rst_;
      vq.push_back(v);
   endtask

   task automatic chk(input string nm, input int idx,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s [%0d]: got %h expected %h",
                  nm, idx, act, exp);
      end
   endtask

   task automatic chk_idle(input string nm, input int idx);
      chk({nm, ".iwait"}, idx, 32'(iwait), 32'd1);
      chk({nm, ".dwait"}, idx, 32'(dwait), 32'd1);
      chk({nm, ".iload"}, idx, iload, 32'd0);
      chk({nm, ".dload"}, idx, dload, 32'd0);
      chk({nm, ".ramREN"}, idx, 32'(ramREN), 32'd0);
      chk({nm, ".ramWEN"}, idx, 32'(ramWEN), 32'd0);
      chk({nm, ".ramaddr"}, idx, ramaddr, 32'd0);
      chk({nm, ".ramstore"}, idx, ramstore, 32'd0);
   endtask

   task automatic zero_in();
      iREN = 0; iaddr = '0; dREN = 0; dWEN = 0;
      daddr = '0; dstore = '0; ramload = '0;
      ramstate = FREE;
   endtask

   initial begin
      string gs;
      int    ng;
      // lone fetch
      add(1,'h40,0,0,0,0,0,FREE,     1,0,1,0,0,0,0,0);
      add(1,'h40,0,0,0,0,0,BUSY,     1,0,1,0,1,0,'h40,0);
      add(1,'h40,0,0,0,0,0,BUSY,     1,0,1,0,1,0,'h40,0);
      add(1,'h40,0,0,0,0,'hDEADBEEF,ACCESS,
          0,'hDEADBEEF,1,0,1,0,'h40,0);
      add(0,0,0,0,0,0,0,FREE,        1,0,1,0,0,0,0,0);
      // write priority
      add(0,0,1,1,'h204,'h12345678,0,FREE,
          1,0,1,0,0,0,0,0);
      add(0,0,1,1,'h204,'h12345678,0,BUSY,
          1,0,1,0,0,1,'h204,'h12345678);
      add(0,0,1,1,'h204,'h12345678,0,ACCESS,
          1,0,0,0,0,1,'h204,'h12345678);
      add(0,0,0,0,0,0,0,FREE,        1,0,1,0,0,0,0,0);
      // block read with icache pending
      add(1,'h80,1,0,'h100,0,0,FREE, 1,0,1,0,0,0,0,0);
      add(1,'h80,1,0,'h100,0,'h11111111,ACCESS,
          1,0,0,'h11111111,1,0,'h100,0);
      add(1,'h80,1,0,'h104,0,'hFFFFFFFF,FREE,
          1,0,1,0,0,0,0,0);
      add(1,'h80,1,0,'h104,0,'h22222222,ACCESS,
          1,0,0,'h22222222,1,0,'h104,0);
      add(1,'h80,0,0,0,0,0,FREE,     1,0,1,0,0,0,0,0);
      add(1,'h80,0,0,0,0,'h33333333,ACCESS,
          0,'h33333333,1,0,1,0,'h80,0);
      add(0,0,0,0,0,0,0,FREE,        1,0,1,0,0,0,0,0);
      // withdrawal while BUSY
      add(0,0,1,0,'h300,0,0,FREE,    1,0,1,0,0,0,0,0);
      add(0,0,1,0,'h300,0,0,BUSY,    1,0,1,0,1,0,'h300,0);
      add(0,0,0,0,'h300,0,0,BUSY,    1,0,1,0,0,0,'h300,0);
      add(0,0,1,0,'h300,0,0,BUSY,    1,0,1,0,0,0,0,0);
      add(0,0,0,0,'h300,0,0,FREE,    1,0,1,0,0,0,'h300,0);
      add(0,0,0,0,0,0,0,FREE,        1,0,1,0,0,0,0,0);

      // reset with random inputs
      for (int i = 0; i < 5; i++) begin
         @(negedge CLK);
         iREN = 1'($urandom); iaddr = $urandom;
         dREN = 1'($urandom); dWEN = 1'($urandom);
         daddr = $urandom; dstore = $urandom;
         ramload = $urandom;
         ramstate = ramstate_t'(2'($urandom));
         #1 chk_idle("reset", i);
      end
      @(negedge CLK);
      zero_in();
      RST = 0;

      for (int i = 0; i < vq.size(); i++) begin
         @(negedge CLK);
         iREN = vq[i].iren; iaddr = vq[i].ia;
         dREN = vq[i].dren; dWEN = vq[i].dwen;
         daddr = vq[i].da; dstore = vq[i].ds;
         ramload = vq[i].rl; ramstate = vq[i].rs;
         #1;
         chk("iwait", i, 32'(iwait), 32'(vq[i].e_iw));
         chk("iload", i, iload, vq[i].e_il);
         chk("dwait", i, 32'(dwait), 32'(vq[i].e_dw));
         chk("dload", i, dload, vq[i].e_dl);
         chk("ramREN", i, 32'(ramREN), 32'(vq[i].e_rr));
         chk("ramWEN", i, 32'(ramWEN), 32'(vq[i].e_rw));
         chk("ramaddr", i, ramaddr, vq[i].e_ra);
         chk("ramstore", i, ramstore, vq[i].e_rs);
      end

      // ERROR holds the data grant
      @(negedge CLK);
      zero_in();
      dREN = 1; daddr = 'h404;
      @(negedge CLK);
      ramstate = ERROR; ramload = 'h5A5A5A5A;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("err.dwait", i, 32'(dwait), 32'd1);
         chk("err.dload", i, dload, 32'd0);
         chk("err.ramREN", i, 32'(ramREN), 32'd1);
         chk("err.ramaddr", i, ramaddr, 32'h404);
         @(negedge CLK);
      end
      ramstate = ACCESS; ramload = 'hCAFEF00D;
      #1;
      chk("err.done", 0, 32'(dwait), 32'd0);
      chk("err.dload", 5, dload, 32'hCAFEF00D);
      @(negedge CLK);
      zero_in();

      // starvation: data wins 4 grants, then icache
      @(negedge CLK);
      iREN = 1; iaddr = 'h500;
      dREN = 1; daddr = 'h604;
      ramstate = ACCESS; ramload = 'h77;
      gs = ""; ng = 0;
      for (int c = 0; c < 40 && ng < 6; c++) begin
         #1;
         if (!iwait && !dwait) gs = {gs, "X"};
         if (!iwait) gs = {gs, "I"};
         if (!dwait) gs = {gs, "D"};
         if (!iwait || !dwait) ng++;
         if (!iwait)
            chk("starve.iaddr", ng, ramaddr, 32'h500);
         @(negedge CLK);
      end
      checks++;
      if (gs != "DDDDID") begin
         errors++;
         $display("FAIL starve.order: got %s expected DDDDID",
                  gs);
      end
      zero_in();

      // async reset mid-transaction
      @(negedge CLK);
      iREN = 1; iaddr = 'h700; ramstate = BUSY;
      @(negedge CLK);
      #1 chk("rst.pre", 0, 32'(ramREN), 32'd1);
      #1 RST = 1; ramstate = ACCESS; ramload = 'h99;
      #1 chk_idle("rst.mid", 0);
      @(negedge CLK);
      RST = 0;
      zero_in();
      @(negedge CLK);
      #1 chk_idle("rst.after", 0);

      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
